// File: rtl/oled_spi_controller.sv
// SSD1331 (PmodOLEDrgb) power-up/init sequencer and pixel streamer with a built-in
// mode-0 SPI byte master. Commands go out with dc_o low, pixel bytes with dc_o high.
module oled_spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int PWR_DLY = 20,
    parameter int RES_DLY = 10,
    parameter int VCC_DLY = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] pixel_i,
    input  logic       pixel_valid_i,
    output logic       pixel_ready_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_o,
    output logic       dc_o,
    output logic       res_o,
    output logic       vccen_o,
    output logic       pmoden_o,
    output logic       busy_o,
    output logic       spi_done_o
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_PWR_ON   = 4'd1;
    localparam logic [3:0] ST_RES_LOW  = 4'd2;
    localparam logic [3:0] ST_RES_HIGH = 4'd3;
    localparam logic [3:0] ST_INIT_CMD = 4'd4;
    localparam logic [3:0] ST_VCC_ON   = 4'd5;
    localparam logic [3:0] ST_DISP_ON  = 4'd6;
    localparam logic [3:0] ST_READY    = 4'd7;
    localparam logic [3:0] ST_PIX_SEND = 4'd8;

    localparam logic [2:0] SP_IDLE = 3'd0;
    localparam logic [2:0] SP_LOAD = 3'd1;
    localparam logic [2:0] SP_LOW  = 3'd2;
    localparam logic [2:0] SP_HIGH = 3'd3;
    localparam logic [2:0] SP_DONE = 3'd4;

    localparam logic [5:0]  ROM_LAST = 6'd41;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] PWR_LAST = 16'(PWR_DLY - 1);
    localparam logic [15:0] RES_LAST = 16'(RES_DLY - 1);
    localparam logic [15:0] VCC_LAST = 16'(VCC_DLY - 1);

    logic [3:0]  r_state;
    logic [15:0] r_cnt;
    logic [5:0]  r_rom_idx;
    logic [7:0]  r_spi_byte;
    logic        r_spi_start;
    logic        r_dc;
    logic        r_res;
    logic        r_vccen;
    logic        r_pmoden;
    logic        r_busy;

    logic [2:0]  r_phase;
    logic [15:0] r_div_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs;
    logic        r_spi_done;

    logic        w_byte_end;

    // Init command list, including the trailing clear-window command.
    function automatic logic [7:0] f_rom(input logic [5:0] idx);
        case (idx)
            6'd0:  f_rom = 8'hAE;  6'd1:  f_rom = 8'hA0;  6'd2:  f_rom = 8'h72;
            6'd3:  f_rom = 8'hA1;  6'd4:  f_rom = 8'h00;  6'd5:  f_rom = 8'hA2;
            6'd6:  f_rom = 8'h00;  6'd7:  f_rom = 8'hA4;  6'd8:  f_rom = 8'hA8;
            6'd9:  f_rom = 8'h3F;  6'd10: f_rom = 8'hAD;  6'd11: f_rom = 8'h8E;
            6'd12: f_rom = 8'hB0;  6'd13: f_rom = 8'h0B;  6'd14: f_rom = 8'hB1;
            6'd15: f_rom = 8'h31;  6'd16: f_rom = 8'hB3;  6'd17: f_rom = 8'hF0;
            6'd18: f_rom = 8'h8A;  6'd19: f_rom = 8'h64;  6'd20: f_rom = 8'h8B;
            6'd21: f_rom = 8'h78;  6'd22: f_rom = 8'h8C;  6'd23: f_rom = 8'h64;
            6'd24: f_rom = 8'hBB;  6'd25: f_rom = 8'h3A;  6'd26: f_rom = 8'hBE;
            6'd27: f_rom = 8'h3E;  6'd28: f_rom = 8'h87;  6'd29: f_rom = 8'h06;
            6'd30: f_rom = 8'h81;  6'd31: f_rom = 8'h91;  6'd32: f_rom = 8'h82;
            6'd33: f_rom = 8'h50;  6'd34: f_rom = 8'h83;  6'd35: f_rom = 8'h7D;
            6'd36: f_rom = 8'h2E;  6'd37: f_rom = 8'h25;  6'd38: f_rom = 8'h00;
            6'd39: f_rom = 8'h00;  6'd40: f_rom = 8'h5F;  6'd41: f_rom = 8'h3F;
            default: f_rom = 8'h00;
        endcase
    endfunction

    // Last cycle of a byte: lets the next command launch right after spi_done_o.
    assign w_byte_end = (r_phase == SP_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rom_idx   <= '0;
            r_spi_byte  <= '0;
            r_spi_start <= 1'b0;
            r_dc        <= 1'b0;
            r_res       <= 1'b1;
            r_vccen     <= 1'b0;
            r_pmoden    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_spi_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state  <= ST_PWR_ON;
                        r_pmoden <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                ST_PWR_ON: begin
                    if (r_cnt == PWR_LAST) begin
                        r_state <= ST_RES_LOW;
                        r_res   <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RES_LOW: begin
                    if (r_cnt == RES_LAST) begin
                        r_state <= ST_RES_HIGH;
                        r_res   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RES_HIGH: begin
                    if (r_cnt == RES_LAST) begin
                        r_state     <= ST_INIT_CMD;
                        r_rom_idx   <= '0;
                        r_spi_byte  <= f_rom(6'd0);
                        r_spi_start <= 1'b1;
                        r_dc        <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_INIT_CMD: begin
                    if (w_byte_end) begin
                        if (r_rom_idx == ROM_LAST) begin
                            r_state <= ST_VCC_ON;
                            r_vccen <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_rom_idx   <= r_rom_idx + 6'd1;
                            r_spi_byte  <= f_rom(r_rom_idx + 6'd1);
                            r_spi_start <= 1'b1;
                        end
                    end
                end
                ST_VCC_ON: begin
                    if (r_cnt == VCC_LAST) begin
                        r_state     <= ST_DISP_ON;
                        r_spi_byte  <= 8'hAF;
                        r_spi_start <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DISP_ON: begin
                    if (r_spi_done) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (pixel_valid_i) begin
                        r_state     <= ST_PIX_SEND;
                        r_spi_byte  <= pixel_i;
                        r_spi_start <= 1'b1;
                        r_dc        <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_PIX_SEND: begin
                    if (r_spi_done) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // SPI byte engine: one load cycle, then 8 x (CLK_DIV low, CLK_DIV high).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_phase    <= SP_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs       <= 1'b1;
            r_spi_done <= 1'b0;
        end else begin
            r_spi_done <= 1'b0;
            case (r_phase)
                SP_IDLE: begin
                    if (r_spi_start) begin
                        r_cs      <= 1'b0;
                        r_mosi    <= r_spi_byte[7];
                        r_shift   <= {r_spi_byte[6:0], 1'b0};
                        r_bit_cnt <= '0;
                        r_phase   <= SP_LOAD;
                    end
                end
                SP_LOAD: begin
                    r_div_cnt <= '0;
                    r_phase   <= SP_LOW;
                end
                SP_LOW: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_sclk    <= 1'b1;
                        r_div_cnt <= '0;
                        r_phase   <= SP_HIGH;
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                SP_HIGH: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_sclk    <= 1'b0;
                        r_div_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_cs    <= 1'b1;
                            r_phase <= SP_DONE;
                        end else begin
                            r_mosi    <= r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_phase   <= SP_LOW;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                SP_DONE: begin
                    r_spi_done <= 1'b1;
                    r_phase    <= SP_IDLE;
                end
                default: r_phase <= SP_IDLE;
            endcase
        end
    end

    assign pixel_ready_o = (r_state == ST_READY);
    assign sclk_o        = r_sclk;
    assign mosi_o        = r_mosi;
    assign cs_o          = r_cs;
    assign dc_o          = r_dc;
    assign res_o         = r_res;
    assign vccen_o       = r_vccen;
    assign pmoden_o      = r_pmoden;
    assign busy_o        = r_busy;
    assign spi_done_o    = r_spi_done;

endmodule

// File: tb/tb_oled_spi_controller.sv
// Directed bench: two controllers (CLK_DIV 4 and 1) with an SPI monitor that
// captures bytes and counts waveform violations.
module tb_oled_spi_controller;

    localparam int D0 = 4;
    localparam int D1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, valid0 = 1'b0, start1 = 1'b0, valid1 = 1'b0;
    logic [7:0] pix0 = 8'h77, pix1 = 8'h5A;
    wire  [1:0] sclk, mosi, cs, dc, res, vccen, pmoden, busy, ready, done;
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    oled_spi_controller #(.CLK_DIV(D0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .pixel_i(pix0),
        .pixel_valid_i(valid0), .pixel_ready_o(ready[0]), .sclk_o(sclk[0]),
        .mosi_o(mosi[0]), .cs_o(cs[0]), .dc_o(dc[0]), .res_o(res[0]),
        .vccen_o(vccen[0]), .pmoden_o(pmoden[0]), .busy_o(busy[0]),
        .spi_done_o(done[0])
    );

    oled_spi_controller #(.CLK_DIV(D1), .PWR_DLY(4), .RES_DLY(3), .VCC_DLY(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .pixel_i(pix1),
        .pixel_valid_i(valid1), .pixel_ready_o(ready[1]), .sclk_o(sclk[1]),
        .mosi_o(mosi[1]), .cs_o(cs[1]), .dc_o(dc[1]), .res_o(res[1]),
        .vccen_o(vccen[1]), .pmoden_o(pmoden[1]), .busy_o(busy[1]),
        .spi_done_o(done[1])
    );

    logic [7:0] rom_exp [0:42] = '{
        8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
        8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64,
        8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06,
        8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E, 8'h25, 8'h00, 8'h00,
        8'h5F, 8'h3F, 8'hAF};
    logic [7:0] pix_seq [0:4] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D};

    // Monitor state, per DUT where indexed.
    logic [8:0] cap0 [$];
    logic [8:0] cap1 [$];
    int         cyc = 0;
    logic [1:0] p_sclk = 2'b00, p_mosi = 2'b00, p_cs = 2'b11;
    logic [7:0] shreg [2];
    int         bits [2] = '{0, 0};
    int         cslow [2] = '{0, 0};
    int         last_rise [2] = '{0, 0};
    int         rise_cyc [2] = '{-100, -100};
    int         done_cnt [2] = '{0, 0};
    int         aborted [2] = '{0, 0};
    int         v_idle [2] = '{0, 0};
    int         v_mosi [2] = '{0, 0};
    int         v_per [2] = '{0, 0};
    int         v_len [2] = '{0, 0};
    int         v_done [2] = '{0, 0};
    int         res_low = 0, res_len = 0, vcc_rise_bytes = -1;
    logic       vcc_at_af = 1'b0, p_res = 1'b1, p_vcc = 1'b0;

    initial begin : mon
        int dv;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                dv = (k == 0) ? D0 : D1;
                if (cs[k] === 1'b1 && sclk[k] !== 1'b0) v_idle[k]++;
                if (sclk[k] === 1'b1 && mosi[k] !== p_mosi[k]) v_mosi[k]++;
                if (p_sclk[k] === 1'b0 && sclk[k] === 1'b1) begin
                    if (bits[k] > 0 && cyc - last_rise[k] != 2 * dv) v_per[k]++;
                    last_rise[k] = cyc;
                    shreg[k] = {shreg[k][6:0], mosi[k]};
                    bits[k]++;
                end
                if (cs[k] === 1'b0) cslow[k]++;
                if (p_cs[k] === 1'b0 && cs[k] === 1'b1) begin
                    rise_cyc[k] = cyc;
                    if (bits[k] == 8) begin
                        if (cslow[k] != 1 + 16 * dv) v_len[k]++;
                        if (k == 0) begin
                            cap0.push_back({dc[0], shreg[0]});
                            if (shreg[0] == 8'hAF && dc[0] == 1'b0) vcc_at_af = vccen[0];
                        end else begin
                            cap1.push_back({dc[1], shreg[1]});
                        end
                    end else begin
                        aborted[k]++;
                    end
                    bits[k]  = 0;
                    cslow[k] = 0;
                end
                if (done[k] === 1'b1) begin
                    done_cnt[k]++;
                    if (cyc - rise_cyc[k] != 1) v_done[k]++;
                end
            end
            if (res[0] === 1'b0) res_low++;
            else if (p_res === 1'b0) begin
                res_len = res_low;
                res_low = 0;
            end
            if (vccen[0] === 1'b1 && p_vcc === 1'b0) vcc_rise_bytes = cap0.size();
            p_res  = res[0];
            p_vcc  = vccen[0];
            p_sclk = sclk;
            p_mosi = mosi;
            p_cs   = cs;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sel: 0 ready0, 1 done0, 2 ready1, 3 done1, 4 cs0 low
    task automatic wait_for(input string tag, input int sel, input int budget);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = (ready[0] === 1'b1);
                1: hit = (done[0] === 1'b1);
                2: hit = (ready[1] === 1'b1);
                3: hit = (done[1] === 1'b1);
                default: hit = (cs[0] === 1'b0);
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic run_init0(input logic with_valid);
        valid0 = with_valid;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("pmoden_on", 32'(pmoden[0]), 32'd1);
        check("busy_on", 32'(busy[0]), 32'd1);
        wait_for("init_ready", 0, 8000);
        valid0 = 1'b0;
        check("init_busy", 32'(busy[0]), 32'd0);
        check("init_cnt", cap0.size(), 32'd43);
        for (int i = 0; i < 43 && i < cap0.size(); i++)
            check($sformatf("cmd%0d", i), 32'(cap0[i]), {23'd0, 1'b0, rom_exp[i]});
        check("res_low_len", res_len, 32'd10);
        check("vcc_before_af", vcc_rise_bytes, 32'd42);
        check("vcc_at_af", 32'(vcc_at_af), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int dn;
        repeat (3) @(negedge clk);
        check("rst_outs0", {22'd0, sclk[0], mosi[0], cs[0], dc[0], res[0], vccen[0],
              pmoden[0], busy[0], ready[0], done[0]}, 32'b0010100000);
        check("rst_outs1", {22'd0, sclk[1], mosi[1], cs[1], dc[1], res[1], vccen[1],
              pmoden[1], busy[1], ready[1], done[1]}, 32'b0010100000);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_busy", 32'(busy[0]), 32'd0);
        check("idle_pmod", 32'(pmoden[0]), 32'd0);
        check("idle_bytes", cap0.size() + done_cnt[0], 32'd0);

        // Init with pixel_valid held high throughout.
        run_init0(1'b1);

        pix0 = pix_seq[0];
        valid0 = 1'b1;
        @(negedge clk);
        check("acc_cs", 32'(cs[0]), 32'd1);
        check("acc_busy", 32'(busy[0]), 32'd1);
        check("acc_ready", 32'(ready[0]), 32'd0);
        @(negedge clk);
        check("acc_cs_low", 32'(cs[0]), 32'd0);
        wait_for("pix_done0", 1, 200);
        valid0 = 1'b0;
        for (int i = 1; i < 5; i++) begin
            wait_for("pix_ready", 0, 10);
            pix0 = pix_seq[i];
            valid0 = 1'b1;
            wait_for("pix_done", 1, 200);
            valid0 = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("pix_cnt", cap0.size(), 32'd48);
        for (int i = 0; i < 5; i++)
            check($sformatf("pix%0d", i), 32'(cap0[43 + i]), {23'd0, 1'b1, pix_seq[i]});
        check("pix_busy", 32'(busy[0]), 32'd0);

        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (30) @(negedge clk);
        check("rdy_start_ready", 32'(ready[0]), 32'd1);
        check("rdy_start_busy", 32'(busy[0]), 32'd0);
        check("rdy_start_bytes", cap0.size(), 32'd48);

        // Fast-clock instance.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_for("init1", 2, 3000);
        valid1 = 1'b1;
        wait_for("done1", 3, 100);
        valid1 = 1'b0;
        repeat (3) @(negedge clk);
        check("d1_cnt", cap1.size(), 32'd44);
        check("d1_first", 32'(cap1[0]), 32'h0AE);
        check("d1_pix", 32'(cap1[43]), 32'h15A);

        // Reset during bit 3 of a pixel.
        dn = done_cnt[0];
        pix0 = 8'hA5;
        valid0 = 1'b1;
        wait_for("mid_cs", 4, 10);
        valid0 = 1'b0;
        repeat (27) @(negedge clk);
        check("mid_bits", bits[0], 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_cs_hi", 32'(cs[0]), 32'd1);
        check("mid_sclk", 32'(sclk[0]), 32'd0);
        check("mid_busy", 32'(busy[0]), 32'd0);
        check("mid_pmod", 32'(pmoden[0]), 32'd0);
        check("mid_dc", 32'(dc[0]), 32'd0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("mid_no_done", done_cnt[0], dn);
        check("mid_abort", aborted[0], 32'd1);
        check("mid_idle", 32'(ready[0] | busy[0] | pmoden[0]), 32'd0);

        cap0.delete();
        vcc_rise_bytes = -1;
        vcc_at_af = 1'b0;
        run_init0(1'b0);

        for (int k = 0; k < 2; k++) begin
            check($sformatf("sclk_idle%0d", k), v_idle[k], 32'd0);
            check($sformatf("mosi_stable%0d", k), v_mosi[k], 32'd0);
            check($sformatf("bit_period%0d", k), v_per[k], 32'd0);
            check($sformatf("cs_len%0d", k), v_len[k], 32'd0);
            check($sformatf("done_pos%0d", k), v_done[k], 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
